mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_BITWIDTH, default 32, the byte-address width on both sides.
REQ-002 SHALL have input clk, 1 bit, the system clock; all state changes on its rising edge.
REQ-003 SHALL have input rst_n, 1 bit, reset; asynchronous, active-low.
REQ-004 SHALL have input req_valid, 1 bit, which starts a request when sampled high in IDLE.
REQ-005 SHALL have input req_address, ADDR_BITWIDTH bits, the byte address of the request.
REQ-006 SHALL have input req_read_type, 3 bits: 000 none, 001 byte, 010 half, 011 word, 101 signed byte, 110 signed half.
REQ-007 SHALL have input req_write_type, 2 bits: 00 none, 01 byte, 10 half, 11 word.
REQ-008 SHALL have input req_data, 32 bits, the store data, right-aligned.
REQ-009 SHALL have output req_ready, 1 bit, which is high only in IDLE.
REQ-010 SHALL have output rsp_data, 32 bits, the load result, right-aligned and extended.
REQ-011 SHALL have output rsp_done, 1 bit, a one-cycle pulse on completion.
REQ-012 SHALL have output rsp_fault, 1 bit, a one-cycle pulse on an illegal request.
REQ-013 SHALL have outputs c_enable (1 bit), c_address (ADDR_BITWIDTH bits), c_data_in (32 bits) and c_write_enable (4 bits), all driving the cache.
REQ-014 SHALL have inputs c_data_out (32 bits), c_data_out_ready (1 bit) and c_busy (1 bit), all from the cache.

Function
REQ-015 SHALL latch address, types and data on acceptance, so the requester may change them afterwards.
REQ-016 SHALL implement the states IDLE, WORD0, WORD1, DONE and FAULT.
REQ-017 SHALL, on acceptance, go to FAULT if both types are nonzero, or if read type is 100 or 111; otherwise it SHALL go to WORD0.
REQ-018 SHALL go to DONE with no cache access when both types are zero.
REQ-019 SHALL, in WORDn, drive c_address as the word-aligned address (word n = base + 4n), c_enable = 1, and c_write_enable / c_data_in as the byte lanes shifted by address[1:0].
REQ-020 SHALL hold c_address, c_write_enable and c_data_in stable for every cycle c_busy is high, plus the first cycle it is sampled low (the cache hold rule).
REQ-021 SHALL complete a WORDn access on the cycle after c_busy is first sampled low; loads SHALL capture c_data_out on that completion cycle.
REQ-022 SHALL merge load lanes: word0 supplies bytes at offset address[1:0] upward, and word1 supplies the remaining low bytes.
REQ-023 SHALL sign-extend signed loads from bit 7 or bit 15 and zero-extend unsigned loads.
REQ-024 SHALL, in DONE, pulse rsp_done for one cycle, keep rsp_data valid until the next acceptance, and return to IDLE.
REQ-025 SHALL, in FAULT, pulse rsp_fault for one cycle with c_enable low, and return to IDLE.
REQ-026 SHALL force c_write_enable to 0 outside WORD0 and WORD1.
REQ-027 SHALL drive c_enable low in IDLE, DONE and FAULT.
REQ-028 SHALL ignore req_valid outside IDLE; it SHALL be sampled again only when req_ready is high.

Reset
REQ-029 SHALL, on rst_n low, immediately set state = IDLE and drive req_ready=1, rsp_done=0, rsp_fault=0, c_enable=0, c_write_enable=0, rsp_data=0, c_address=0 and c_data_in=0.
REQ-030 SHALL abandon an in-flight access when reset is asserted mid-access; no partial-merge result SHALL be reported.

Configuration
REQ-031 SHALL support macro MISALIGNED_SPLIT_EN.
REQ-032 SHALL, when MISALIGNED_SPLIT_EN is defined, split a half at offset 3, or a word at offset 1-3, into WORD0 followed by WORD1; aligned or in-word accesses SHALL skip WORD1.
REQ-033 SHALL, when MISALIGNED_SPLIT_EN is undefined, send a word-crossing access to FAULT with no cache access; WORD1 SHALL be unreachable.

Verification
REQ-034 SHALL cover an aligned word store followed by a load: store 0x1000 = 0xDEADBEEF, then load word 0x1000 -> rsp_data 0xDEADBEEF; the store shows c_write_enable 1111.
REQ-035 SHALL cover a signed byte load: memory word 0x1004 = 0x80FF7F01, load signed byte at 0x1007 -> rsp_data 0xFFFFFF80; load unsigned byte at 0x1007 -> 0x00000080.
REQ-036 SHALL cover a half store at offset 2: store half at 0x1002 = 0xABCD -> c_write_enable 1100, c_data_in 0xABCD0000; word reload -> upper 16 bits 0xABCD.
REQ-037 SHALL cover a misaligned word with a 0x1000/0x1004 cross-word pattern: word0=0x33221100, word1=0x77665544, load word 0x1001 -> with MISALIGNED_SPLIT_EN rsp_data 0x44332211 after two accesses; without it, rsp_fault pulses and c_enable stays 0.
REQ-038 SHALL cover a miss stall: hold c_busy high 20 cycles -> c_address and c_write_enable are unchanged through the stall and one more cycle, then rsp_done pulses once.
REQ-039 SHALL cover illegal requests and reset: read type 011 with write type 01 -> rsp_fault pulses with no cache access; rst_n low during WORD1 -> outputs at reset values and no rsp_done.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer between a requester and a cache: byte-lane alignment, sign extension,
// cache busy handshake. Define MISALIGNED_SPLIT_EN to split word-crossing accesses into two words.
module mem_access_unit #(
    parameter int ADDR_BITWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic [ADDR_BITWIDTH-1:0] req_address,
    input  logic [2:0]               req_read_type,
    input  logic [1:0]               req_write_type,
    input  logic [31:0]              req_data,
    output logic                     req_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_done,
    output logic                     rsp_fault,
    output logic                     c_enable,
    output logic [ADDR_BITWIDTH-1:0] c_address,
    output logic [31:0]              c_data_in,
    output logic [3:0]               c_write_enable,
    input  logic [31:0]              c_data_out,
    input  logic                     c_data_out_ready,
    input  logic                     c_busy
);

    // state | meaning
    // IDLE  | ready for a request
    // WORD0 | cache access to the word holding the base address
    // WORD1 | cache access to the following word (split accesses only)
    // DONE  | one-cycle completion pulse
    // FAULT | one-cycle illegal-request pulse
    typedef enum logic [2:0] {IDLE, WORD0, WORD1, DONE, FAULT} state_t;

    state_t state, state_next;

    logic [ADDR_BITWIDTH-1:0] addr_q;
    logic [2:0]               rt_q;
    logic [1:0]               wt_q;
    logic [31:0]              data_q;
    logic [31:0]              word0_q;
    logic [31:0]              rsp_data_q;
    logic                     seen_low;

    // size code: 0 byte, 1 half, 2 word
    function automatic logic [1:0] access_size(input logic [2:0] rt, input logic [1:0] wt);
        if (rt != 3'b000) return rt[1:0] - 2'd1;
        return wt - 2'd1;
    endfunction

    function automatic logic crosses(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd1 && off == 2'd3) || (size == 2'd2 && off != 2'd0);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] m, input logic [2:0] rt);
        case (rt[1:0])
            2'b01:   return rt[2] ? {{24{m[7]}}, m[7:0]} : {24'b0, m[7:0]};
            2'b10:   return rt[2] ? {{16{m[15]}}, m[15:0]} : {16'b0, m[15:0]};
            default: return m;
        endcase
    endfunction

    logic                     illegal_in;
    logic                     none_in;
    logic [1:0]               size_q;
    logic [1:0]               off_q;
    logic [7:0]               we_wide;
    logic [63:0]              data_wide;
    logic [63:0]              load_pair;
    logic [31:0]              load_merged;
    logic [ADDR_BITWIDTH-1:0] base_addr;
    logic                     split_q;
    logic                     final_word;
    logic                     unused_ready;

    assign unused_ready = c_data_out_ready;

    assign illegal_in = (req_read_type != 3'b000 && req_write_type != 2'b00)
                      || req_read_type == 3'b100 || req_read_type == 3'b111;
    assign none_in    = (req_read_type == 3'b000 && req_write_type == 2'b00);

    assign size_q    = access_size(rt_q, wt_q);
    assign off_q     = addr_q[1:0];
    assign we_wide   = (wt_q != 2'b00) ? ({4'b0000, lane_mask(size_q)} << off_q) : 8'h00;
    assign data_wide = {32'b0, data_q} << {off_q, 3'b000};
    assign base_addr = {addr_q[ADDR_BITWIDTH-1:2], 2'b00};

    // word1 supplies the bytes above the end of word0 once shifted down
    assign load_pair   = ((state == WORD1) ? {c_data_out, word0_q} : {32'b0, c_data_out})
                         >> {off_q, 3'b000};
    assign load_merged = load_pair[31:0];

`ifdef MISALIGNED_SPLIT_EN
    assign split_q = crosses(size_q, off_q);
`else
    logic crossing_in;
    assign crossing_in = crosses(access_size(req_read_type, req_write_type), req_address[1:0]);
    assign split_q     = 1'b0;
`endif

    assign final_word = seen_low && ((state == WORD0 && !split_q) || state == WORD1);
    assign rsp_data   = rsp_data_q;

    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        rsp_done       = 1'b0;
        rsp_fault      = 1'b0;
        c_enable       = 1'b0;
        c_address      = '0;
        c_data_in      = '0;
        c_write_enable = 4'b0000;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (illegal_in)   state_next = FAULT;
                    else if (none_in) state_next = DONE;
`ifdef MISALIGNED_SPLIT_EN
                    else              state_next = WORD0;
`else
                    else              state_next = crossing_in ? FAULT : WORD0;
`endif
                end
            end
            WORD0: begin
                c_enable       = 1'b1;
                c_address      = base_addr;
                c_write_enable = we_wide[3:0];
                c_data_in      = data_wide[31:0];
                if (seen_low) state_next = split_q ? WORD1 : DONE;
            end
            WORD1: begin
                c_enable       = 1'b1;
                c_address      = base_addr + {{(ADDR_BITWIDTH-3){1'b0}}, 3'd4};
                c_write_enable = we_wide[7:4];
                c_data_in      = data_wide[63:32];
                if (seen_low) state_next = DONE;
            end
            DONE: begin
                rsp_done   = 1'b1;
                state_next = IDLE;
            end
            FAULT: begin
                rsp_fault  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            rt_q       <= 3'b000;
            wt_q       <= 2'b00;
            data_q     <= 32'h0;
            word0_q    <= 32'h0;
            rsp_data_q <= 32'h0;
            seen_low   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                addr_q <= req_address;
                rt_q   <= req_read_type;
                wt_q   <= req_write_type;
                data_q <= req_data;
            end
            // outputs stay put through the cycle after busy is first seen low
            if (state == WORD0 || state == WORD1) begin
                if (seen_low)     seen_low <= 1'b0;
                else if (!c_busy) seen_low <= 1'b1;
            end else begin
                seen_low <= 1'b0;
            end
            if (state == WORD0 && seen_low) word0_q <= c_data_out;
            if (final_word && rt_q != 3'b000) rsp_data_q <= extend(load_merged, rt_q);
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte-lane cache model; expectations
// adapt to whether MISALIGNED_SPLIT_EN is defined.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_address;
    logic [2:0]  req_read_type;
    logic [1:0]  req_write_type;
    logic [31:0] req_data;
    logic        req_ready;
    logic [31:0] rsp_data;
    logic        rsp_done;
    logic        rsp_fault;
    logic        c_enable;
    logic [31:0] c_address;
    logic [31:0] c_data_in;
    logic [3:0]  c_write_enable;
    logic [31:0] c_data_out;
    logic        c_data_out_ready;
    logic        c_busy;

    int total;
    int bad;

    logic [31:0] mem [0:63];

    mem_access_unit #(.ADDR_BITWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_address(req_address),
        .req_read_type(req_read_type), .req_write_type(req_write_type),
        .req_data(req_data), .req_ready(req_ready),
        .rsp_data(rsp_data), .rsp_done(rsp_done), .rsp_fault(rsp_fault),
        .c_enable(c_enable), .c_address(c_address), .c_data_in(c_data_in),
        .c_write_enable(c_write_enable), .c_data_out(c_data_out),
        .c_data_out_ready(c_data_out_ready), .c_busy(c_busy)
    );

    always #5 clk = ~clk;

    assign c_data_out       = mem[c_address[7:2]];
    assign c_data_out_ready = c_enable && !c_busy;

    always @(posedge clk) begin
        if (c_enable && !c_busy) begin
            for (int b = 0; b < 4; b++)
                if (c_write_enable[b]) mem[c_address[7:2]][8*b +: 8] <= c_data_in[8*b +: 8];
        end
    end

    // issue one request, scramble the inputs after acceptance, observe a fixed window
    task automatic do_req(input logic [31:0] a, input logic [2:0] rt, input logic [1:0] wt,
                          input logic [31:0] d, output int n_done, output int n_fault,
                          output int n_en, output logic [3:0] we_obs, output logic [31:0] din_obs,
                          output logic [31:0] addr_last);
        n_done = 0; n_fault = 0; n_en = 0; we_obs = 4'h0; din_obs = 32'h0; addr_last = 32'h0;
        @(negedge clk);
        req_address = a; req_read_type = rt; req_write_type = wt; req_data = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_address = $urandom; req_read_type = 3'($urandom); req_write_type = 2'($urandom);
        req_data = $urandom;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (c_enable) begin
                n_en++;
                addr_last = c_address;
                if (c_write_enable != 4'h0) begin
                    we_obs  = c_write_enable;
                    din_obs = c_data_in;
                end
            end
            if (rsp_done)  n_done++;
            if (rsp_fault) n_fault++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total += 8;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        if (rsp_done !== 1'b0) begin bad++; $display("FAIL reset_rsp_done got %b want 0", rsp_done); end
        if (rsp_fault !== 1'b0) begin bad++; $display("FAIL reset_rsp_fault got %b want 0", rsp_fault); end
        if (c_enable !== 1'b0) begin bad++; $display("FAIL reset_c_enable got %b want 0", c_enable); end
        if (c_write_enable !== 4'h0) begin bad++; $display("FAIL reset_we got %b want 0000", c_write_enable); end
        if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        if (c_address !== 32'h0) begin bad++; $display("FAIL reset_c_address got %h want 0", c_address); end
        if (c_data_in !== 32'h0) begin bad++; $display("FAIL reset_c_data_in got %h want 0", c_data_in); end
        rst_n = 1'b1;
    endtask

    task automatic test_word_store_load;
        int nd, nf, ne; logic [3:0] we; logic [31:0] din, al;
        do_req(32'h1000, 3'b000, 2'b11, 32'hDEADBEEF, nd, nf, ne, we, din, al);
        total += 4;
        if (nd !== 1) begin bad++; $display("FAIL sw_done_count got %0d want 1", nd); end
        if (we !== 4'b1111) begin bad++; $display("FAIL sw_we got %b want 1111", we); end
        if (din !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_data_in got %h want deadbeef", din); end
        if (al !== 32'h1000) begin bad++; $display("FAIL sw_address got %h want 1000", al); end
        do_req(32'h1000, 3'b011, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total += 3;
        if (nd !== 1) begin bad++; $display("FAIL lw_done_count got %0d want 1", nd); end
        if (we !== 4'h0) begin bad++; $display("FAIL lw_we got %b want 0000", we); end
        if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got %h want deadbeef", rsp_data); end
    endtask

    task automatic test_signed_loads;
        int nd, nf, ne; logic [3:0] we; logic [31:0] din, al;
        do_req(32'h1004, 3'b000, 2'b11, 32'h80FF7F01, nd, nf, ne, we, din, al);
        do_req(32'h1007, 3'b101, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total++;
        if (rsp_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_signed got %h want ffffff80", rsp_data); end
        do_req(32'h1007, 3'b001, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total++;
        if (rsp_data !== 32'h00000080) begin bad++; $display("FAIL lb_unsigned got %h want 00000080", rsp_data); end
        do_req(32'h1006, 3'b110, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total++;
        if (rsp_data !== 32'hFFFF80FF) begin bad++; $display("FAIL lh_signed_neg got %h want ffff80ff", rsp_data); end
        do_req(32'h1004, 3'b110, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total++;
        if (rsp_data !== 32'h00007F01) begin bad++; $display("FAIL lh_signed_pos got %h want 00007f01", rsp_data); end
        do_req(32'h1006, 3'b010, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total++;
        if (rsp_data !== 32'h000080FF) begin bad++; $display("FAIL lh_unsigned got %h want 000080ff", rsp_data); end
    endtask

    task automatic test_half_store;
        int nd, nf, ne; logic [3:0] we; logic [31:0] din, al;
        do_req(32'h1002, 3'b000, 2'b10, 32'h0000ABCD, nd, nf, ne, we, din, al);
        total += 2;
        if (we !== 4'b1100) begin bad++; $display("FAIL sh_we got %b want 1100", we); end
        if (din !== 32'hABCD0000) begin bad++; $display("FAIL sh_data_in got %h want abcd0000", din); end
        do_req(32'h1000, 3'b011, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total++;
        if (rsp_data !== 32'hABCDBEEF) begin bad++; $display("FAIL sh_reload got %h want abcdbeef", rsp_data); end
    endtask

    task automatic test_misaligned;
        int nd, nf, ne; logic [3:0] we; logic [31:0] din, al;
        do_req(32'h1000, 3'b000, 2'b11, 32'h33221100, nd, nf, ne, we, din, al);
        do_req(32'h1004, 3'b000, 2'b11, 32'h77665544, nd, nf, ne, we, din, al);
        do_req(32'h1003, 3'b001, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total += 2;
        if (rsp_data !== 32'h00000033) begin bad++; $display("FAIL lbu_off3 got %h want 00000033", rsp_data); end
        if (ne !== 2) begin bad++; $display("FAIL lbu_off3_accesses got %0d want 2", ne); end
        do_req(32'h1001, 3'b011, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total += 3;
`ifdef MISALIGNED_SPLIT_EN
        if (rsp_data !== 32'h44332211) begin bad++; $display("FAIL mis_word_data got %h want 44332211", rsp_data); end
        if (ne !== 4) begin bad++; $display("FAIL mis_word_enable_cycles got %0d want 4", ne); end
        if (al !== 32'h1004) begin bad++; $display("FAIL mis_word_addr1 got %h want 1004", al); end
`else
        if (nf !== 1) begin bad++; $display("FAIL mis_word_fault got %0d want 1", nf); end
        if (ne !== 0) begin bad++; $display("FAIL mis_word_enable_cycles got %0d want 0", ne); end
        if (nd !== 0) begin bad++; $display("FAIL mis_word_done got %0d want 0", nd); end
`endif
        do_req(32'h1003, 3'b010, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total++;
`ifdef MISALIGNED_SPLIT_EN
        if (rsp_data !== 32'h00004433) begin bad++; $display("FAIL mis_half_data got %h want 00004433", rsp_data); end
`else
        if (nf !== 1) begin bad++; $display("FAIL mis_half_fault got %0d want 1", nf); end
`endif
    endtask

    task automatic test_stall;
        int moved; int nd;
        int nd2, nf, ne; logic [3:0] we; logic [31:0] din, al;
        moved = 0; nd = 0;
        @(negedge clk);
        req_address = 32'h1008; req_read_type = 3'b000; req_write_type = 2'b11;
        req_data = 32'h12345678; req_valid = 1'b1; c_busy = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_address = 32'h0; req_data = 32'h0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (c_enable !== 1'b1 || c_address !== 32'h1008 || c_write_enable !== 4'b1111
                || c_data_in !== 32'h12345678) moved++;
            if (rsp_done) nd++;
        end
        c_busy = 1'b0;
        @(negedge clk);
        if (c_enable !== 1'b1 || c_address !== 32'h1008 || c_write_enable !== 4'b1111) moved++;
        if (rsp_done) nd++;
        total++;
        if (moved !== 0) begin bad++; $display("FAIL stall_hold got %0d changed cycles want 0", moved); end
        @(negedge clk);
        total++;
        if (rsp_done !== 1'b1) begin bad++; $display("FAIL stall_done_timing got %b want 1", rsp_done); end
        if (rsp_done) nd++;
        repeat (5) begin
            @(negedge clk);
            if (rsp_done) nd++;
        end
        total++;
        if (nd !== 1) begin bad++; $display("FAIL stall_done_count got %0d want 1", nd); end
        do_req(32'h1008, 3'b011, 2'b00, 32'h0, nd2, nf, ne, we, din, al);
        total++;
        if (rsp_data !== 32'h12345678) begin bad++; $display("FAIL stall_reload got %h want 12345678", rsp_data); end
    endtask

    task automatic test_illegal;
        int nd, nf, ne; logic [3:0] we; logic [31:0] din, al;
        do_req(32'h1000, 3'b011, 2'b01, 32'hFFFFFFFF, nd, nf, ne, we, din, al);
        total += 3;
        if (nf !== 1) begin bad++; $display("FAIL ill_rw_fault got %0d want 1", nf); end
        if (ne !== 0) begin bad++; $display("FAIL ill_rw_access got %0d want 0", ne); end
        if (nd !== 0) begin bad++; $display("FAIL ill_rw_done got %0d want 0", nd); end
        do_req(32'h1000, 3'b100, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total++;
        if (nf !== 1 || ne !== 0) begin bad++; $display("FAIL ill_rt100 got fault=%0d en=%0d want 1/0", nf, ne); end
        do_req(32'h1000, 3'b111, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total++;
        if (nf !== 1 || ne !== 0) begin bad++; $display("FAIL ill_rt111 got fault=%0d en=%0d want 1/0", nf, ne); end
        do_req(32'h1000, 3'b000, 2'b00, 32'h0, nd, nf, ne, we, din, al);
        total++;
        if (nd !== 1 || nf !== 0 || ne !== 0)
            begin bad++; $display("FAIL none_req got done=%0d fault=%0d en=%0d want 1/0/0", nd, nf, ne); end
    endtask

    task automatic test_reset_mid;
        int nd; nd = 0;
        @(negedge clk);
`ifdef MISALIGNED_SPLIT_EN
        req_address = 32'h1001;
`else
        req_address = 32'h1004;
`endif
        req_read_type = 3'b011; req_write_type = 2'b00; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        repeat (3) @(negedge clk);
`else
        @(negedge clk);
`endif
        total++;
        if (c_enable !== 1'b1 || c_address !== 32'h1004)
            begin bad++; $display("FAIL mid_pre_reset got en=%b addr=%h want 1/1004", c_enable, c_address); end
        rst_n = 1'b0;
        #1;
        total += 5;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_req_ready got %b want 1", req_ready); end
        if (c_enable !== 1'b0) begin bad++; $display("FAIL mid_c_enable got %b want 0", c_enable); end
        if (c_write_enable !== 4'h0) begin bad++; $display("FAIL mid_we got %b want 0000", c_write_enable); end
        if (c_address !== 32'h0) begin bad++; $display("FAIL mid_c_address got %h want 0", c_address); end
        if (rsp_data !== 32'h0) begin bad++; $display("FAIL mid_rsp_data got %h want 0", rsp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_done) nd++;
        end
        total++;
        if (nd !== 0) begin bad++; $display("FAIL mid_no_done got %0d want 0", nd); end
    endtask

    initial begin
        total = 0; bad = 0;
        clk = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_address = 32'h0;
        req_read_type = 3'b000; req_write_type = 2'b00; req_data = 32'h0; c_busy = 1'b0;
        test_reset();
        test_word_store_load();
        test_signed_loads();
        test_half_store();
        test_misaligned();
        test_stall();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
